pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 1: payload width in bits.
REQ-002 SHALL have parameter INIT, default all-zero WIDTH bits: DEQ_DATA value while empty and under reset.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CLR  input  1  synchronous flush of all held entries.
REQ-006 SHALL have port ENQ_VALID  input  1  upstream offers ENQ_DATA.
REQ-007 SHALL have port ENQ_DATA  input  WIDTH  upstream payload.
REQ-008 SHALL have port ENQ_RDY  output  1  stage accepts a beat this cycle.
REQ-009 SHALL have port DEQ_VALID  output  1  DEQ_DATA holds a valid beat.
REQ-010 SHALL have port DEQ_DATA  output  WIDTH  head payload; feeds the downstream register D_IN.
REQ-011 SHALL have port DEQ_RDY  input  1  downstream consumes the head this cycle; drives the downstream register EN with DEQ_VALID.

Function
REQ-012 SHALL complete an enqueue on posedge when ENQ_VALID and ENQ_RDY are both 1, and a dequeue when DEQ_VALID and DEQ_RDY are both 1.
REQ-013 SHALL hold two storage entries, main (head) and skid, and track occupancy in states EMPTY, ONE and TWO.
REQ-014 SHALL drive ENQ_RDY, DEQ_VALID and DEQ_DATA directly from flops; no combinational path from any input to any output.
REQ-015 SHALL set ENQ_RDY=1 in EMPTY and ONE and ENQ_RDY=0 in TWO.
REQ-016 SHALL set DEQ_VALID=1 in ONE and TWO, and DEQ_VALID=0 in EMPTY.
REQ-017 SHALL apply these transitions: EMPTY+enq->ONE; ONE+enq only->TWO (beat to skid); ONE+deq only->EMPTY; ONE+enq+deq->ONE (beat to main); TWO+deq->ONE (skid moves to main); otherwise hold.
REQ-018 SHALL present a beat on DEQ_DATA in the cycle after its enqueue (latency 1) when the stage was EMPTY, or ONE with a simultaneous dequeue.
REQ-019 SHALL preserve order; with DEQ_RDY held at 1, SHALL sustain one beat per cycle.
REQ-020 SHALL keep DEQ_DATA stable while DEQ_VALID=1 and DEQ_RDY=0.
REQ-021 SHALL drive DEQ_DATA=INIT in EMPTY.
REQ-022 SHALL, on CLR=1, go to EMPTY next cycle and discard any same-cycle enqueue; a same-cycle dequeue still counts as consumed by downstream.
REQ-023 SHALL ignore ENQ_DATA when ENQ_VALID=0, and ignore ENQ_VALID when ENQ_RDY=0.

Reset
REQ-024 SHALL, on posedge with RST=1, enter EMPTY and set ENQ_RDY=0, DEQ_VALID=0, DEQ_DATA=INIT; RST overrides CLR and all handshakes.
REQ-025 SHALL raise ENQ_RDY=1 on the first posedge with RST=0.
REQ-026 SHALL discard held beats and restart from EMPTY when RST asserts mid-operation.

Configuration
REQ-027 SHALL support the macro PIPE_SKID_XFER_CNT_EN.
REQ-028 SHALL, when PIPE_SKID_XFER_CNT_EN is defined, add output XFER_CNT (16 bits): count of completed dequeues, wrapping 0xFFFF->0x0000, cleared by RST but not by CLR.
REQ-029 SHALL, when PIPE_SKID_XFER_CNT_EN is undefined, have no XFER_CNT port and no counter logic.

Structure
REQ-030 SHALL put the occupancy-state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the counter width constant (16) in the shared pipeline package.
REQ-031 SHALL use one sub-module, pipe_skid_entry: a WIDTH-wide enabled data register with synchronous reset to INIT, instantiated twice (main, skid).

Verification
REQ-032 SHALL cover: RST high 3 cycles, then released -> DEQ_VALID=0 and DEQ_DATA=INIT throughout; ENQ_RDY=0 during reset and 1 one cycle after release.
REQ-033 SHALL cover: WIDTH=8, DEQ_RDY=1, enqueue 0x01..0x10 back-to-back -> same 16 values out in order, one per cycle, first beat one cycle after its enqueue.
REQ-034 SHALL cover: DEQ_RDY=0, enqueue 0xA1, 0xA2 -> ENQ_RDY=0 after the second beat, DEQ_DATA holds 0xA1; raise DEQ_RDY -> 0xA1, then 0xA2; ENQ_RDY=1 one cycle after the first dequeue.
REQ-035 SHALL cover: state TWO, assert CLR with ENQ_VALID=1 and ENQ_DATA=0x55 -> next cycle DEQ_VALID=0, DEQ_DATA=INIT, and 0x55 never appears.
REQ-036 SHALL cover: RST asserted in state ONE with DEQ_RDY=1 -> next cycle EMPTY, no further DEQ_VALID until a new enqueue.
REQ-037 SHALL cover, with PIPE_SKID_XFER_CNT_EN: 65537 dequeues -> XFER_CNT=1 (wrap); CLR leaves XFER_CNT unchanged.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the skid-buffer pipeline stage: occupancy
// state encoding and the width of the optional transfer counter
// (enabled with the PIPE_SKID_XFER_CNT_EN macro).
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for the skid stage. The master side is the
// environment (upstream producer plus downstream consumer); the slave side
// is the stage itself.
interface pipe_skid_stage_if #(
  parameter int WIDTH = 1
);

  logic             ENQ_VALID;
  logic [WIDTH-1:0] ENQ_DATA;
  logic             ENQ_RDY;
  logic             DEQ_VALID;
  logic [WIDTH-1:0] DEQ_DATA;
  logic             DEQ_RDY;

  modport master (
    output ENQ_VALID, ENQ_DATA, DEQ_RDY,
    input  ENQ_RDY, DEQ_VALID, DEQ_DATA
  );

  modport slave (
    input  ENQ_VALID, ENQ_DATA, DEQ_RDY,
    output ENQ_RDY, DEQ_VALID, DEQ_DATA
  );

endinterface

// File: rtl/pipe_skid_entry.sv
// One storage slot of the skid stage: a WIDTH-wide register with load
// enable and synchronous reset to INIT.
module pipe_skid_entry #(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the payload until a new value is loaded; reset returns to INIT.
  always_ff @(posedge CLK) begin
    if (RST)     q <= INIT;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage. All outputs come straight from
// flops, so the stage breaks every combinational path between upstream
// and downstream. Defining PIPE_SKID_XFER_CNT_EN adds a 16-bit XFER_CNT
// output counting completed dequeues.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
`ifdef PIPE_SKID_XFER_CNT_EN
  output logic [XFER_CNT_W-1:0] XFER_CNT,
`endif
  pipe_skid_stage_if.slave      bus
);

  occ_state_t       state_q;
  occ_state_t       state_d;
  logic             enq_rdy_q;
  logic             deq_valid_q;
  logic             enq_fire;
  logic             deq_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign enq_fire      = bus.ENQ_VALID & enq_rdy_q;
  assign deq_fire      = deq_valid_q & bus.DEQ_RDY;
  assign bus.ENQ_RDY   = enq_rdy_q;
  assign bus.DEQ_VALID = deq_valid_q;
  assign bus.DEQ_DATA  = main_q;

  // Occupancy register; the handshake flags are precomputed from the next
  // state so they are registered yet exact in the cycle they apply to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      enq_rdy_q   <= 1'b0;
      deq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      enq_rdy_q   <= (state_d != TWO);
      deq_valid_q <= (state_d != EMPTY);
    end
  end

  // Next occupancy from the completed enqueue/dequeue handshakes.
  always_comb begin
    state_d = state_q;
    if (CLR) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (enq_fire) state_d = ONE;
        ONE: begin
          if (enq_fire && !deq_fire)      state_d = TWO;
          else if (!enq_fire && deq_fire) state_d = EMPTY;
        end
        TWO:     if (deq_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Entry load controls: main always holds the head (INIT when empty),
  // skid only catches a beat that arrives while main is stalled.
  always_comb begin
    main_en = 1'b0;
    main_d  = bus.ENQ_DATA;
    skid_en = 1'b0;
    if (CLR) begin
      main_en = 1'b1;
      main_d  = INIT;
    end else begin
      case (state_q)
        EMPTY: main_en = enq_fire;
        ONE: begin
          if (deq_fire) begin
            main_en = 1'b1;
            main_d  = enq_fire ? bus.ENQ_DATA : INIT;
          end else begin
            skid_en = enq_fire;
          end
        end
        TWO: begin
          if (deq_fire) begin
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: begin
          main_en = 1'b1;
          main_d  = INIT;
        end
      endcase
    end
  end

  pipe_skid_entry #(.WIDTH(WIDTH), .INIT(INIT)) u_main (
    .CLK (CLK),
    .RST (RST),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_skid_entry #(.WIDTH(WIDTH), .INIT(INIT)) u_skid (
    .CLK (CLK),
    .RST (RST),
    .en  (skid_en),
    .d   (bus.ENQ_DATA),
    .q   (skid_q)
  );

`ifdef PIPE_SKID_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] xfer_cnt_q;

  assign XFER_CNT = xfer_cnt_q;

  // Free-running dequeue counter; a flush does not clear it.
  always_ff @(posedge CLK) begin
    if (RST)           xfer_cnt_q <= '0;
    else if (deq_fire) xfer_cnt_q <= xfer_cnt_q + XFER_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage (WIDTH=8, non-zero INIT). A scoreboard
// queue is filled from accepted enqueues and drained on dequeues; directed
// steps check handshake flags, latency, flush and reset behaviour. The
// counter checks are active when PIPE_SKID_XFER_CNT_EN is defined.
module tb_pipe_skid_stage;

  localparam int         W      = 8;
  localparam logic [7:0] INIT_V = 8'hC3;

  logic CLK = 1'b0;
  logic RST;
  logic CLR;
  logic mon_en = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  logic [7:0] sb_q[$];
`ifdef PIPE_SKID_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  pipe_skid_stage_if #(.WIDTH(W)) bus ();

  pipe_skid_stage #(.WIDTH(W), .INIT(INIT_V)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CLR      (CLR),
`ifdef PIPE_SKID_XFER_CNT_EN
    .XFER_CNT (xfer_cnt),
`endif
    .bus      (bus)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle when inputs and outputs are stable.
  always @(negedge CLK) begin
    logic [7:0] exp;
    if (mon_en) begin
      if (RST) begin
        sb_q.delete();
      end else begin
        if (bus.DEQ_VALID && bus.DEQ_RDY) begin
          check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check("sb_data", 32'(bus.DEQ_DATA), 32'(exp));
          end
        end
        if (!bus.DEQ_VALID) check("empty_init", 32'(bus.DEQ_DATA), 32'(INIT_V));
        if (CLR) sb_q.delete();
        else if (bus.ENQ_VALID && bus.ENQ_RDY) sb_q.push_back(bus.ENQ_DATA);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RST = 1'b1;
    CLR = 1'b0;
    bus.ENQ_VALID = 1'b0;
    bus.ENQ_DATA  = 8'hEE;
    bus.DEQ_RDY   = 1'b0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      cycle();
      mon_en = 1'b1;
      check("rst_enq_rdy", 32'(bus.ENQ_RDY), 32'd0);
      check("rst_deq_valid", 32'(bus.DEQ_VALID), 32'd0);
      check("rst_deq_data", 32'(bus.DEQ_DATA), 32'(INIT_V));
    end
    RST = 1'b0;
    cycle();
    check("rel_enq_rdy", 32'(bus.ENQ_RDY), 32'd1);
    check("rel_deq_valid", 32'(bus.DEQ_VALID), 32'd0);
    cycle();
    check("idle_deq_valid", 32'(bus.DEQ_VALID), 32'd0);

    // Back-to-back stream with the consumer always ready.
    bus.DEQ_RDY = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.ENQ_VALID = 1'b1;
      bus.ENQ_DATA  = 8'(i);
      cycle();
      check("stream_valid", 32'(bus.DEQ_VALID), 32'd1);
      check("stream_data", 32'(bus.DEQ_DATA), 32'(i));
      check("stream_enq_rdy", 32'(bus.ENQ_RDY), 32'd1);
    end
    bus.ENQ_VALID = 1'b0;
    bus.ENQ_DATA  = 8'hEE;
    cycle();
    check("stream_drained", 32'(bus.DEQ_VALID), 32'd0);
    check("stream_sb_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure: fill both entries, then drain.
    bus.DEQ_RDY   = 1'b0;
    bus.ENQ_VALID = 1'b1;
    bus.ENQ_DATA  = 8'hA1;
    cycle();
    check("bp_a1_head", 32'(bus.DEQ_DATA), 32'hA1);
    check("bp_one_rdy", 32'(bus.ENQ_RDY), 32'd1);
    bus.ENQ_DATA = 8'hA2;
    cycle();
    check("bp_full_rdy", 32'(bus.ENQ_RDY), 32'd0);
    check("bp_hold_a1", 32'(bus.DEQ_DATA), 32'hA1);
    bus.ENQ_DATA = 8'hA3;
    cycle();
    check("bp_still_full", 32'(bus.ENQ_RDY), 32'd0);
    check("bp_stable_a1", 32'(bus.DEQ_DATA), 32'hA1);
    bus.ENQ_VALID = 1'b0;
    bus.DEQ_RDY   = 1'b1;
    cycle();
    check("bp_a2_head", 32'(bus.DEQ_DATA), 32'hA2);
    check("bp_rdy_back", 32'(bus.ENQ_RDY), 32'd1);
    cycle();
    check("bp_drained", 32'(bus.DEQ_VALID), 32'd0);
    check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Flush in state TWO with a competing (refused) enqueue of 0x55.
    bus.DEQ_RDY   = 1'b0;
    bus.ENQ_VALID = 1'b1;
    bus.ENQ_DATA  = 8'hB1;
    cycle();
    bus.ENQ_DATA = 8'hB2;
    cycle();
    check("clr_pre_full", 32'(bus.ENQ_RDY), 32'd0);
    CLR = 1'b1;
    bus.ENQ_DATA = 8'h55;
    cycle();
    check("clr_two_valid", 32'(bus.DEQ_VALID), 32'd0);
    check("clr_two_data", 32'(bus.DEQ_DATA), 32'(INIT_V));
    check("clr_two_rdy", 32'(bus.ENQ_RDY), 32'd1);

    // Flush in state ONE while an accepted-looking enqueue of 0x55 is offered.
    CLR = 1'b0;
    bus.ENQ_DATA = 8'hC1;
    cycle();
    CLR = 1'b1;
    bus.ENQ_DATA = 8'h55;
    cycle();
    check("clr_one_valid", 32'(bus.DEQ_VALID), 32'd0);
    CLR = 1'b0;
    bus.ENQ_VALID = 1'b0;
    cycle();
    check("clr_no_55", 32'(bus.DEQ_VALID), 32'd0);
    bus.DEQ_RDY   = 1'b1;
    bus.ENQ_VALID = 1'b1;
    bus.ENQ_DATA  = 8'h66;
    cycle();
    check("clr_fresh", 32'(bus.DEQ_DATA), 32'h66);
    bus.ENQ_VALID = 1'b0;
    cycle();

    // Reset asserted while one beat is held.
    bus.DEQ_RDY   = 1'b0;
    bus.ENQ_VALID = 1'b1;
    bus.ENQ_DATA  = 8'hD1;
    cycle();
    check("mid_one_head", 32'(bus.DEQ_DATA), 32'hD1);
    bus.ENQ_VALID = 1'b0;
    bus.DEQ_RDY   = 1'b1;
    RST = 1'b1;
    cycle();
    check("mid_rst_valid", 32'(bus.DEQ_VALID), 32'd0);
    check("mid_rst_rdy", 32'(bus.ENQ_RDY), 32'd0);
    check("mid_rst_data", 32'(bus.DEQ_DATA), 32'(INIT_V));
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("mid_rst_idle", 32'(bus.DEQ_VALID), 32'd0);
    end
    bus.ENQ_VALID = 1'b1;
    bus.ENQ_DATA  = 8'hE1;
    cycle();
    check("mid_rst_new", 32'(bus.DEQ_DATA), 32'hE1);
    bus.ENQ_VALID = 1'b0;
    cycle();

`ifdef PIPE_SKID_XFER_CNT_EN
    // Dequeue counter wrap and flush immunity.
    RST = 1'b1;
    cycle();
    check("cnt_reset", 32'(xfer_cnt), 32'd0);
    RST = 1'b0;
    cycle();
    bus.DEQ_RDY = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bus.ENQ_VALID = 1'b1;
      bus.ENQ_DATA  = 8'(i);
      cycle();
    end
    bus.ENQ_VALID = 1'b0;
    cycle();
    check("cnt_wrap", 32'(xfer_cnt), 32'd1);
    bus.DEQ_RDY   = 1'b0;
    bus.ENQ_VALID = 1'b1;
    bus.ENQ_DATA  = 8'h77;
    cycle();
    bus.ENQ_VALID = 1'b0;
    bus.DEQ_RDY   = 1'b1;
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
    check("cnt_clr_deq", 32'(xfer_cnt), 32'd2);
    check("cnt_clr_valid", 32'(bus.DEQ_VALID), 32'd0);
    cycle();
    check("cnt_clr_hold", 32'(xfer_cnt), 32'd2);
`endif

    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
